// File: rtl/sequenciador_transmissao_ascii.sv
// Sequences a latched ASCII message, one character at a time, through a serial transmitter.
// Optional macro SEQ_PARA_NUL_EN: stop the message at the first NUL character.
module sequenciador_transmissao_ascii #(
  parameter int N_CHARS    = 8,
  parameter int CHAR_WIDTH = 7,
  parameter int GAP_CYCLES = 2,
  localparam int IDX_W     = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          iniciar,
  input  logic [N_CHARS*CHAR_WIDTH-1:0] dados_ascii,
  output logic                          tx_partida,
  output logic [CHAR_WIDTH-1:0]         tx_dados,
  input  logic                          tx_pronto,
  output logic [IDX_W-1:0]              indice,
  output logic                          ocupado,
  output logic                          pronto,
  output logic [2:0]                    db_estado
);

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    CARREGA   = 3'd1,
    ENVIA     = 3'd2,
    ESPERA    = 3'd3,
    INTERVALO = 3'd4,
    PROXIMO   = 3'd5,
    FINAL     = 3'd6
  } estado_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] ULTIMO  = IDX_W'(N_CHARS - 1);
  localparam logic [GAP_W-1:0] GAP_ULT = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  estado_t                            estado_q, estado_d;
  logic [N_CHARS-1:0][CHAR_WIDTH-1:0] msg_q, msg_d;
  logic [IDX_W-1:0]                   indice_q, indice_d;
  logic [GAP_W-1:0]                   gap_q, gap_d;
  logic [IDX_W-1:0]                   indice_inc;
  logic [CHAR_WIDTH-1:0]              char_atual;

  assign indice_inc = indice_q + 1'b1;
  assign char_atual = msg_q[indice_q];

`ifdef SEQ_PARA_NUL_EN
  logic [CHAR_WIDTH-1:0] char_prox;
  assign char_prox = msg_q[indice_inc];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      msg_q    <= '0;
      indice_q <= '0;
      gap_q    <= '0;
    end else begin
      estado_q <= estado_d;
      msg_q    <= msg_d;
      indice_q <= indice_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    msg_d    = msg_q;
    indice_d = indice_q;
    gap_d    = gap_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = CARREGA;
      end
      CARREGA: begin
        msg_d    = dados_ascii;
        indice_d = '0;
`ifdef SEQ_PARA_NUL_EN
        // A leading NUL is routed through PROXIMO, which sees it as the current char and ends.
        estado_d = (dados_ascii[CHAR_WIDTH-1:0] == '0) ? PROXIMO : ENVIA;
`else
        estado_d = ENVIA;
`endif
      end
      ENVIA: begin
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (tx_pronto) begin
          gap_d    = '0;
          estado_d = (GAP_CYCLES > 0) ? INTERVALO : PROXIMO;
        end
      end
      INTERVALO: begin
        if (gap_q == GAP_ULT) estado_d = PROXIMO;
        else                  gap_d    = gap_q + 1'b1;
      end
      PROXIMO: begin
`ifdef SEQ_PARA_NUL_EN
        if (indice_q == ULTIMO || char_atual == '0 || char_prox == '0) begin
`else
        if (indice_q == ULTIMO) begin
`endif
          estado_d = FINAL;
        end else begin
          indice_d = indice_inc;
          estado_d = ENVIA;
        end
      end
      FINAL: begin
        estado_d = INICIAL;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  // Every output is decoded from registered state only.
  assign tx_partida = (estado_q == ENVIA);
  assign pronto     = (estado_q == FINAL);
  assign ocupado    = (estado_q != INICIAL);
  assign tx_dados   = char_atual;
  assign indice     = indice_q;
  assign db_estado  = estado_q;

endmodule

// File: doc/sequenciador_transmissao_ascii.md
Name: sequenciador_transmissao_ascii

Overview:
Control unit that sends a buffer of ASCII characters one at a time through a single-character serial transmitter. It latches the whole message on `iniciar`, then for each character it drives the character, pulses `tx_partida`, and waits for `tx_pronto`. An optional idle gap is inserted between characters, and `pronto` is pulsed when the message is done. It sits between the system-level control and the serial transmitter datapath, and is the sequencer for the multi-character transmit path.

Parameters:
- N_CHARS, 8: number of characters per message, must be ≥ 1.
- CHAR_WIDTH, 7: bits per ASCII character.
- GAP_CYCLES, 2: idle clock cycles between `tx_pronto` and the next `tx_partida`; 0 means no gap.

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- iniciar, input, 1: start request; sampled only in state INICIAL.
- dados_ascii, input, N_CHARS*CHAR_WIDTH: message. Character k is bits [k*CHAR_WIDTH +: CHAR_WIDTH]; character 0 is sent first.
- tx_partida, output, 1: one-cycle start pulse to the serial transmitter.
- tx_dados, output, CHAR_WIDTH: character currently being sent.
- tx_pronto, input, 1: serial transmitter has finished the current character.
- indice, output, clog2(N_CHARS) (minimum 1): index of the current character.
- ocupado, output, 1: high in every state except INICIAL.
- pronto, output, 1: one-cycle pulse when the message is complete.
- db_estado, output, 3: state encoding, for debug.

Behaviour:
- Reset (`reset`=0, takes effect immediately):
  - state becomes INICIAL;
  - `tx_partida`=0, `pronto`=0, `ocupado`=0;
  - `indice`=0, `tx_dados`=0, message register cleared, gap counter cleared.
- All outputs are registered or decoded from the registered state; no combinational path from input to output.
- State encoding: INICIAL=0, CARREGA=1, ENVIA=2, ESPERA=3, INTERVALO=4, PROXIMO=5, FINAL=6.
- INICIAL: if `iniciar`=1 go to CARREGA, else stay.
- CARREGA (1 cycle): latch `dados_ascii` into the internal register, set `indice`=0, go to ENVIA. Later changes to `dados_ascii` do not affect this message.
- ENVIA (1 cycle):
  - `tx_partida`=1;
  - `tx_dados`=char[`indice`];
  - go to ESPERA;
  - `tx_pronto` is ignored in this cycle (stale flag from the previous character).
- ESPERA:
  - `tx_dados` is held stable;
  - stay until `tx_pronto`=1;
  - then go to INTERVALO if GAP_CYCLES>0, else go to PROXIMO.
- INTERVALO: count exactly GAP_CYCLES cycles, then go to PROXIMO; the counter is cleared on entry.
- PROXIMO (1 cycle): if `indice`==N_CHARS-1 go to FINAL; else increment `indice` and go to ENVIA.
- FINAL (1 cycle): `pronto`=1, then go to INICIAL. `tx_dados` keeps the last character until the next CARREGA.
- `iniciar` asserted outside INICIAL is ignored and not queued. `iniciar` held high re-triggers on the cycle after FINAL.
- Per-character timing: `tx_partida` pulses are separated by (1 + ESPERA cycles + GAP_CYCLES + 1) clocks.
  - ESPERA cycles are counted up to and including the cycle in which `tx_pronto` is seen.
  - Total for the message: 2 + Σ(per character) + 1 cycles from the `iniciar` edge to the `pronto` edge.
- `tx_pronto` high continuously in ESPERA: accepted on the first ESPERA cycle. This is legal; the transmitter owns the timing.
- Reset in the middle of a message: the sequence is abandoned, with no `pronto` and no further `tx_partida`; the next message restarts at character 0.
- `indice` never exceeds N_CHARS-1. There is no wrap-around; FINAL always terminates the message.

Optional Feature:
- Macro: `SEQ_PARA_NUL_EN`.
- Defined: in PROXIMO (and also before the first ENVIA), the block checks whether the next character to send equals 0 (NUL).
  - If it is NUL, go straight to FINAL; NUL is never transmitted.
  - An all-NUL message goes CARREGA → PROXIMO → FINAL with no `tx_partida`; `pronto` still pulses.
- Not defined: all N_CHARS characters are always sent, including NUL.

Test Plan:
1. Reset then idle: hold `reset`=0 for 3 cycles, release, keep `iniciar`=0 → all outputs 0, `db_estado`=0, no `tx_partida`.
2. Full message:
   - Stimulus: `dados_ascii` = "HELLO123" (char 0 = 0x48 ... char 7 = 0x33); the transmitter model returns `tx_pronto` 10 cycles after each `tx_partida`; GAP_CYCLES=2.
   - Required: 8 `tx_partida` pulses with `tx_dados` 0x48,0x45,0x4C,0x4C,0x4F,0x31,0x32,0x33; pulse spacing 14 cycles; one `pronto` pulse; `indice` steps 0..7.
3. Input change and ignored start: change `dados_ascii` and pulse `iniciar` during ESPERA of character 2 → transmitted characters unchanged, no second message after `pronto`.
4. Reset during transmission: assert `reset` in ESPERA of character 4 → `tx_partida`, `ocupado`, `indice` go to 0 immediately; a new `iniciar` restarts from char 0 = 0x48.
5. Zero gap and back-to-back: GAP_CYCLES=0, `tx_pronto` tied to 1, `iniciar` held at 1 → `tx_partida` every 3 cycles; messages back-to-back with `pronto` every 27 cycles.
6. NUL termination (`SEQ_PARA_NUL_EN` defined): message "AB" followed by 6×0x00 → exactly 2 `tx_partida` pulses (0x41, 0x42), then `pronto`; with the macro undefined → 8 pulses.
